player_damage_ctl: RTL

PLAYER_DAMAGE_CTL -- requirements
Module: player_damage_ctl

---
 rtl/player_damage_ctl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/player_damage_ctl.sv
// Player damage FSM: box-vs-pixel collision drives hit/hp/invulnerability/death; outputs registered, 1-cycle latency, no backpressure.
// Optional DAMAGE_BLINK_EN: sprite blinks during invulnerability; otherwise player_visible is tied high.
module player_damage_ctl #(
    parameter int MAX_HP        = 3,
    parameter int PLAYER_SIZE   = 32,
    parameter int INVULN_CYCLES = 32000000,
    parameter int BLINK_CYCLES  = 4000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        game_on,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output logic [3:0]  hp,
    output logic        hit,
    output logic        invulnerable,
    output logic        game_over,
    output logic        player_visible
);

    if (MAX_HP < 1 || MAX_HP > 15 || PLAYER_SIZE < 1 || INVULN_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_chk
        $error("player_damage_ctl: parameter out of range");
    end

    localparam int          ICW      = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [3:0]  HP_INIT  = 4'(MAX_HP);
    localparam logic [ICW-1:0] INV_LAST = ICW'(INVULN_CYCLES - 1);
    localparam logic [12:0] BOX_SPAN = 13'(PLAYER_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

    state_t         r_state;
    logic [3:0]     r_hp;
    logic           r_hit;
    logic           r_invuln;
    logic           r_over;
    logic [ICW-1:0] r_inv_cnt;

    // 13-bit bounds so a box near the 4095 edge cannot wrap back to 0.
    logic [12:0] w_ox, w_oy, w_px_lo, w_py_lo, w_px_hi, w_py_hi;
    logic        w_collide;

    assign w_ox    = {1'b0, obstacle_x};
    assign w_oy    = {1'b0, obstacle_y};
    assign w_px_lo = {1'b0, player_x};
    assign w_py_lo = {1'b0, player_y};
    assign w_px_hi = w_px_lo + BOX_SPAN;
    assign w_py_hi = w_py_lo + BOX_SPAN;

    assign w_collide = (|{obstacle_x, obstacle_y})
                     && (w_ox >= w_px_lo) && (w_ox <= w_px_hi)
                     && (w_oy >= w_py_lo) && (w_oy <= w_py_hi);

`ifdef DAMAGE_BLINK_EN
    localparam int          BCW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK_CYCLES - 1);
    logic           r_pvis;
    logic [BCW-1:0] r_blink_cnt;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hp      <= HP_INIT;
            r_hit     <= 1'b0;
            r_invuln  <= 1'b0;
            r_over    <= 1'b0;
            r_inv_cnt <= '0;
`ifdef DAMAGE_BLINK_EN
            r_pvis      <= 1'b1;
            r_blink_cnt <= '0;
`endif
        end else begin
            r_hit <= 1'b0;
            // Dropping game_on wins over any collision seen this cycle.
            if (r_state != IDLE && !game_on) begin
                r_state   <= IDLE;
                r_hp      <= HP_INIT;
                r_invuln  <= 1'b0;
                r_over    <= 1'b0;
                r_inv_cnt <= '0;
`ifdef DAMAGE_BLINK_EN
                r_pvis      <= 1'b1;
                r_blink_cnt <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_hp <= HP_INIT;
                        if (game_on) r_state <= ALIVE;
                    end
                    ALIVE: begin
                        if (w_collide) begin
                            r_hit <= 1'b1;
                            if (r_hp <= 4'd1) begin
                                r_state <= DEAD;
                                r_hp    <= 4'd0;
                                r_over  <= 1'b1;
                            end else begin
                                r_state   <= INVULN;
                                r_hp      <= r_hp - 4'd1;
                                r_invuln  <= 1'b1;
                                r_inv_cnt <= '0;
`ifdef DAMAGE_BLINK_EN
                                r_pvis      <= 1'b0;
                                r_blink_cnt <= '0;
`endif
                            end
                        end
                    end
                    INVULN: begin
                        if (r_inv_cnt == INV_LAST) begin
                            r_state  <= ALIVE;
                            r_invuln <= 1'b0;
`ifdef DAMAGE_BLINK_EN
                            r_pvis   <= 1'b1;
`endif
                        end else begin
                            r_inv_cnt <= r_inv_cnt + 1'b1;
`ifdef DAMAGE_BLINK_EN
                            if (r_blink_cnt == BL_LAST) begin
                                r_blink_cnt <= '0;
                                r_pvis      <= ~r_pvis;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    DEAD: begin
                        r_hp   <= 4'd0;
                        r_over <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign hp           = r_hp;
    assign hit          = r_hit;
    assign invulnerable = r_invuln;
    assign game_over    = r_over;
`ifdef DAMAGE_BLINK_EN
    assign player_visible = r_pvis;
`else
    assign player_visible = 1'b1;
`endif

endmodule
